// File: rtl/pipe_if_stage_if.sv
// Bundle of the fetch-stage control inputs, memory word and IF/ID outputs.
// The stage itself uses the slave modport; whatever drives it uses master.
interface pipe_if_stage_if;
  logic        stall;
  logic        flush;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] rpc;
  logic [31:0] jpc;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] d_pc4;
  logic [31:0] d_inst;
  logic        d_valid;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    output stall, flush, pcsource, bpc, rpc, jpc, inst,
    input  pc, pc4, d_pc4, d_inst, d_valid, fetch_count, stall_count
  );

  modport slave (
    input  stall, flush, pcsource, bpc, rpc, jpc, inst,
    output pc, pc4, d_pc4, d_inst, d_valid, fetch_count, stall_count
  );
endinterface

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register with
// stall/flush handling and saturating fetch/stall counters.
module pipe_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic            clock,
  input logic            reset,
  pipe_if_stage_if.slave bus
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] d_inst_q, d_inst_d;
  logic [31:0] d_pc4_q, d_pc4_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] stallc_q, stallc_d;
  logic [31:0] pc4;
  logic [31:0] target;
  logic [31:0] npc;
  logic        normal;

  assign pc4    = pc_q + 32'd4;
  assign normal = !bus.flush && !bus.stall;

  always_comb begin
    target = pc4;
    case (bus.pcsource)
      2'b00: target = pc4;
      2'b01: target = bus.bpc;
      2'b10: target = bus.rpc;
      2'b11: target = bus.jpc;
      default: target = pc4;
    endcase
    npc = {target[31:2], 2'b00};
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  // Next-state: flush empties, stall holds (including a held bubble)
  always_comb begin
    state_d = state_q;
    if (bus.flush)      state_d = EMPTY;
    else if (!bus.stall) state_d = FULL;
  end

  // Output decode
  always_comb begin
    bus.d_valid = (state_q == FULL);
  end

  always_comb begin
    pc_d     = pc_q;
    d_inst_d = d_inst_q;
    d_pc4_d  = d_pc4_q;
    fetch_d  = fetch_q;
    stallc_d = stallc_q;
    if (bus.flush) begin
      pc_d     = npc;
      d_inst_d = '0;
      d_pc4_d  = '0;
    end else if (bus.stall) begin
      if (stallc_q != '1) stallc_d = stallc_q + 32'd1;
    end else if (normal) begin
      pc_d     = npc;
      d_inst_d = bus.inst;
      d_pc4_d  = pc4;
      if (fetch_q != '1) fetch_d = fetch_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      d_inst_q <= '0;
      d_pc4_q  <= '0;
      fetch_q  <= '0;
      stallc_q <= '0;
    end else begin
      pc_q     <= pc_d;
      d_inst_q <= d_inst_d;
      d_pc4_q  <= d_pc4_d;
      fetch_q  <= fetch_d;
      stallc_q <= stallc_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc4         = pc4;
  assign bus.d_inst      = d_inst_q;
  assign bus.d_pc4       = d_pc4_q;
  assign bus.fetch_count = fetch_q;
  assign bus.stall_count = stallc_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed cases plus randomized
// cycles compared against a cycle-level reference model.
module tb_pipe_if_stage;

  logic clock = 1'b0;
  logic reset;
  int unsigned errors = 0;
  int unsigned checks = 0;

  pipe_if_stage_if bus ();

  pipe_if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Instruction ROM: word at address a is 0x20000000 + a
  assign bus.inst = 32'h2000_0000 + bus.pc;

  logic [31:0] m_pc, m_d_inst, m_d_pc4, m_fc, m_sc;
  logic        m_valid;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic check_all(input string tag);
    check_eq({tag, ".pc"},      bus.pc,          m_pc);
    check_eq({tag, ".pc4"},     bus.pc4,         m_pc + 32'd4);
    check_eq({tag, ".d_inst"},  bus.d_inst,      m_d_inst);
    check_eq({tag, ".d_pc4"},   bus.d_pc4,       m_d_pc4);
    check_eq({tag, ".d_valid"}, {31'd0, bus.d_valid}, {31'd0, m_valid});
    check_eq({tag, ".fetch"},   bus.fetch_count, m_fc);
    check_eq({tag, ".stall"},   bus.stall_count, m_sc);
  endtask

  // One clock: drive at negedge, advance model, check 1 time unit after posedge
  task automatic step(input logic rst, input logic stl, input logic fls,
                      input logic [1:0] src, input logic [31:0] b,
                      input logic [31:0] r, input logic [31:0] j,
                      input string tag);
    logic [31:0] tgt;
    @(negedge clock);
    reset = rst; bus.stall = stl; bus.flush = fls;
    bus.pcsource = src; bus.bpc = b; bus.rpc = r; bus.jpc = j;
    case (src)
      2'd0: tgt = m_pc + 32'd4;
      2'd1: tgt = b;
      2'd2: tgt = r;
      default: tgt = j;
    endcase
    tgt = tgt & 32'hFFFF_FFFC;
    if (rst) begin
      m_pc = 32'h0; m_d_inst = '0; m_d_pc4 = '0; m_valid = 1'b0; m_fc = '0; m_sc = '0;
    end else if (fls) begin
      m_pc = tgt; m_d_inst = '0; m_d_pc4 = '0; m_valid = 1'b0;
    end else if (stl) begin
      m_sc = sat_inc(m_sc);
    end else begin
      m_d_inst = 32'h2000_0000 + m_pc;
      m_d_pc4  = m_pc + 32'd4;
      m_valid  = 1'b1;
      m_fc     = sat_inc(m_fc);
      m_pc     = tgt;
    end
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  task automatic run(input string tag);
    step(1'b0, 1'b0, 1'b0, 2'd0, '0, '0, '0, tag);
  endtask

  task automatic do_reset(input string tag);
    step(1'b1, 1'b0, 1'b0, 2'd0, '0, '0, '0, tag);
  endtask

  initial begin
    reset = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.pcsource = 2'd0; bus.bpc = '0; bus.rpc = '0; bus.jpc = '0;

    // Reset and free-running fetch
    do_reset("reset");
    for (int i = 0; i < 4; i++) run("seq");
    check_eq("seq_pc16", bus.pc, 32'd16);
    check_eq("seq_dinst", bus.d_inst, 32'h2000_000C);
    check_eq("seq_fetch4", bus.fetch_count, 32'd4);

    // Stall for 3 cycles at pc=8
    do_reset("reset2");
    run("pre_stall"); run("pre_stall");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, '0, "stall");
    check_eq("stall_pc", bus.pc, 32'd8);
    check_eq("stall_cnt3", bus.stall_count, 32'd3);
    run("resume");
    check_eq("resume_pc", bus.pc, 32'd12);

    // Branch with delay slot at pc=0x10, misaligned target
    run("to10");
    check_eq("at10", bus.pc, 32'h10);
    step(1'b0, 1'b0, 1'b0, 2'd1, 32'h43, '0, '0, "branch");
    check_eq("br_pc", bus.pc, 32'h40);
    check_eq("br_slot", bus.d_inst, 32'h2000_0010);
    run("br_next");
    check_eq("br_dpc4", bus.d_pc4, 32'h44);

    // Flush beats stall; jump target taken
    step(1'b0, 1'b1, 1'b1, 2'd3, '0, '0, 32'h100, "flush_stall");
    check_eq("fl_pc", bus.pc, 32'h100);
    step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, '0, "stall_empty");
    run("refill");

    // Register jump then wrap at top of address space
    step(1'b0, 1'b0, 1'b0, 2'd2, '0, 32'h0000_0207, '0, "jr");
    step(1'b0, 1'b0, 1'b0, 2'd3, '0, '0, 32'hFFFF_FFFC, "to_top");
    check_eq("wrap_pc4", bus.pc4, 32'h0);
    run("wrap");
    check_eq("wrap_pc", bus.pc, 32'h0);
    check_eq("wrap_dpc4", bus.d_pc4, 32'h0);

    // Reset coinciding with stall and flush
    step(1'b1, 1'b1, 1'b1, 2'd3, '0, '0, 32'h80, "reset_mid");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic rs, st, fl;
      rs = ($urandom_range(0, 49) == 0);
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      step(rs, st, fl, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom, "rand");
    end

    // Counter saturation
    @(negedge clock);
    force dut.fetch_q = 32'hFFFF_FFFE;
    force dut.stallc_q = 32'hFFFF_FFFE;
    #1;
    release dut.fetch_q;
    release dut.stallc_q;
    m_fc = 32'hFFFF_FFFE;
    m_sc = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) run("sat_fetch");
    check_eq("sat_fc", bus.fetch_count, 32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd0, '0, '0, '0, "sat_stall");
    check_eq("sat_sc", bus.stall_count, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 1'b0, 2'd0, '0, '0, '0, "sat_reset");
    check_eq("rst_fc", bus.fetch_count, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
